// File: rtl/multdiv_pkg.sv
// Shared definitions for the multiply/divide controller slice.
// Holds the data and counter widths, the default iteration counts and the
// FSM state encoding used by multdiv_ctrl.
package multdiv_pkg;

    localparam int DATA_W          = 32;
    localparam int CNT_W           = 6;
    localparam int MULT_CYCLES_DEF = 32;
    localparam int DIV_CYCLES_DEF  = 34;

    // Controller states: the full enumeration of the sequencer.
    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_MULT = 2'd1;
    localparam state_t ST_DIV  = 2'd2;
    localparam state_t ST_DONE = 2'd3;

endpackage

// File: rtl/multdiv_if.sv
// Request/response and datapath bundle for multdiv_ctrl.
//   slave  : controller view (requests and dp_result/dp_overflow in,
//            dp_start_*/dp_operand*, data_result*, busy out)
//   master : requester/datapath view, the mirror image
interface multdiv_if;
    import multdiv_pkg::*;

    logic              ctrl_MULT;
    logic              ctrl_DIV;
    logic [DATA_W-1:0] data_operandA;
    logic [DATA_W-1:0] data_operandB;
    logic [DATA_W-1:0] dp_result;
    logic              dp_overflow;
    logic              dp_start_mult;
    logic              dp_start_div;
    logic [DATA_W-1:0] dp_operandA;
    logic [DATA_W-1:0] dp_operandB;
    logic [DATA_W-1:0] data_result;
    logic              data_resultRDY;
    logic              data_exception;
    logic              busy;

    modport slave (
        input  ctrl_MULT, ctrl_DIV, data_operandA, data_operandB,
               dp_result, dp_overflow,
        output dp_start_mult, dp_start_div, dp_operandA, dp_operandB,
               data_result, data_resultRDY, data_exception, busy
    );

    modport master (
        output ctrl_MULT, ctrl_DIV, data_operandA, data_operandB,
               dp_result, dp_overflow,
        input  dp_start_mult, dp_start_div, dp_operandA, dp_operandB,
               data_result, data_resultRDY, data_exception, busy
    );

endinterface

// File: rtl/multdiv_cycle_counter.sv
// Iteration counter for multdiv_ctrl.
// Ports: clock, reset (sync, active high), clear (sync restart to 0),
//        en (count up), sel_div (pick divide terminal count),
//        at_last (count equals the selected terminal value).
module multdiv_cycle_counter
    import multdiv_pkg::*;
#(
    parameter int MULT_LAST = MULT_CYCLES_DEF - 1,
    parameter int DIV_LAST  = DIV_CYCLES_DEF - 1
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic en,
    input  logic sel_div,
    output logic at_last
);

    localparam logic [CNT_W-1:0] MULT_LAST_C = CNT_W'(MULT_LAST);
    localparam logic [CNT_W-1:0] DIV_LAST_C  = CNT_W'(DIV_LAST);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (en) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign at_last = (count_q == (sel_div ? DIV_LAST_C : MULT_LAST_C));

endmodule

// File: rtl/multdiv_ctrl.sv
// Sequencer for a shared iterative multiply/divide datapath.
// Ports: clock, reset (sync, active high), bus (multdiv_if.slave) carrying
//        requests/operands in, datapath start pulses and held operands out,
//        and the registered result, exception, ready pulse and busy flag.
// A request in any state restarts the sequencer; multiply beats divide.
module multdiv_ctrl
    import multdiv_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,  // legal 2..63
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF    // legal 2..63
) (
    input  logic      clock,
    input  logic      reset,
    multdiv_if.slave  bus
);

    state_t            state_q, state_d;
    logic [DATA_W-1:0] op_a_q, op_a_d;
    logic [DATA_W-1:0] op_b_q, op_b_d;
    logic [DATA_W-1:0] result_q, result_d;
    logic              exc_q, exc_d;
    logic              rdy_q, rdy_d;
    logic              busy_q, busy_d;
    logic              start_mult_q, start_mult_d;
    logic              start_div_q, start_div_d;
    logic              div_zero_q, div_zero_d;   // current divide has B == 0
    logic              cnt_clear, cnt_en, cnt_at_last;

    multdiv_cycle_counter #(
        .MULT_LAST (MULT_CYCLES - 1),
        .DIV_LAST  (DIV_CYCLES - 1)
    ) u_counter (
        .clock   (clock),
        .reset   (reset),
        .clear   (cnt_clear),
        .en      (cnt_en),
        .sel_div (state_q == ST_DIV),
        .at_last (cnt_at_last)
    );

    always_comb begin
        state_d      = state_q;
        op_a_d       = op_a_q;
        op_b_d       = op_b_q;
        result_d     = result_q;
        exc_d        = exc_q;
        div_zero_d   = div_zero_q;
        rdy_d        = 1'b0;
        busy_d       = 1'b0;
        start_mult_d = 1'b0;
        start_div_d  = 1'b0;
        cnt_clear    = 1'b0;
        cnt_en       = 1'b0;

        if (bus.ctrl_MULT || bus.ctrl_DIV) begin
            // New request: aborts any operation in flight, no ready for it.
            state_d      = bus.ctrl_MULT ? ST_MULT : ST_DIV;
            op_a_d       = bus.data_operandA;
            op_b_d       = bus.data_operandB;
            busy_d       = 1'b1;
            cnt_clear    = 1'b1;
            div_zero_d   = !bus.ctrl_MULT && (bus.data_operandB == '0);
            start_mult_d = bus.ctrl_MULT;
            // A zero divisor never touches the datapath.
            start_div_d  = !bus.ctrl_MULT && (bus.data_operandB != '0);
        end else begin
            case (state_q)
                ST_MULT: begin
                    if (cnt_at_last) begin
                        result_d = bus.dp_result;
                        exc_d    = bus.dp_overflow;
                        rdy_d    = 1'b1;
                        state_d  = ST_DONE;
                    end else begin
                        busy_d = 1'b1;
                        cnt_en = 1'b1;
                    end
                end
                ST_DIV: begin
                    if (div_zero_q) begin
                        result_d = '0;
                        exc_d    = 1'b1;
                        rdy_d    = 1'b1;
                        state_d  = ST_DONE;
                    end else if (cnt_at_last) begin
                        result_d = bus.dp_result;
                        exc_d    = 1'b0;
                        rdy_d    = 1'b1;
                        state_d  = ST_DONE;
                    end else begin
                        busy_d = 1'b1;
                        cnt_en = 1'b1;
                    end
                end
                ST_DONE: state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            op_a_q       <= '0;
            op_b_q       <= '0;
            result_q     <= '0;
            exc_q        <= 1'b0;
            rdy_q        <= 1'b0;
            busy_q       <= 1'b0;
            start_mult_q <= 1'b0;
            start_div_q  <= 1'b0;
            div_zero_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            op_a_q       <= op_a_d;
            op_b_q       <= op_b_d;
            result_q     <= result_d;
            exc_q        <= exc_d;
            rdy_q        <= rdy_d;
            busy_q       <= busy_d;
            start_mult_q <= start_mult_d;
            start_div_q  <= start_div_d;
            div_zero_q   <= div_zero_d;
        end
    end

    assign bus.dp_start_mult  = start_mult_q;
    assign bus.dp_start_div   = start_div_q;
    assign bus.dp_operandA    = op_a_q;
    assign bus.dp_operandB    = op_b_q;
    assign bus.data_result    = result_q;
    assign bus.data_resultRDY = rdy_q;
    assign bus.data_exception = exc_q;
    assign bus.busy           = busy_q;

endmodule

// File: tb/tb_multdiv_ctrl.sv
// Scoreboard bench for multdiv_ctrl with a cycle-accurate datapath model.
module tb_multdiv_ctrl;

    localparam int MC = 32;
    localparam int DC = 34;

    logic clock = 1'b0;
    logic reset = 1'b1;

    multdiv_if bus();

    multdiv_ctrl #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    int cyc = 0;   // number of the most recent rising edge
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] res;
        logic        exc;
        int          at;
        string       name;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   errors = 0;
    int   checks = 0;
    int   n_smult = 0, n_sdiv = 0, n_busy = 0, n_rdy = 0;

    task automatic check32(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", nm, act, req, cyc);
        end else begin
            $display("ok   %s: %0h (edge %0d)", nm, act, cyc);
        end
    endtask

    // Datapath model: result/overflow valid only in the last busy cycle,
    // garbage otherwise so a mistimed capture is visible.
    int          dp_left = -1;
    logic [31:0] dp_val = '0;
    logic        dp_ovf_val = 1'b0;
    logic        ovf_arm = 1'b0;
    logic [63:0] prod;
    always @(negedge clock) begin
        if (reset) begin
            dp_left = -1;
        end else if (bus.dp_start_mult) begin
            prod       = 64'(bus.dp_operandA) * 64'(bus.dp_operandB);
            dp_val     = prod[31:0];
            dp_ovf_val = ovf_arm;
            dp_left    = MC - 1;
        end else if (bus.dp_start_div) begin
            dp_val     = (bus.dp_operandB != 0) ? bus.dp_operandA / bus.dp_operandB : 32'h0;
            dp_ovf_val = 1'b0;
            dp_left    = DC - 1;
        end else if (dp_left >= 0) begin
            dp_left--;
        end
        if (dp_left == 0) begin
            bus.dp_result   = dp_val;
            bus.dp_overflow = dp_ovf_val;
        end else begin
            bus.dp_result   = 32'hDEADBEEF;
            bus.dp_overflow = 1'b1;
        end
    end

    // Monitor: pulse counters plus scoreboard comparison on every RDY.
    always @(negedge clock) begin
        if (bus.dp_start_mult) n_smult++;
        if (bus.dp_start_div)  n_sdiv++;
        if (bus.busy)          n_busy++;
        if (bus.data_resultRDY) begin
            n_rdy++;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rdy: got RDY at edge %0d, expected none", cyc);
            end else begin
                mon_e = sb.pop_front();
                check32({mon_e.name, "_result"}, bus.data_result, mon_e.res);
                check32({mon_e.name, "_exc"}, 32'(bus.data_exception), 32'(mon_e.exc));
                check32({mon_e.name, "_rdy_edge"}, 32'(cyc), 32'(mon_e.at));
            end
        end else if (sb.size() != 0 && cyc > sb[0].at) begin
            checks++;
            errors++;
            $display("FAIL %s_missing_rdy: got none by edge %0d, expected at %0d", sb[0].name, cyc, sb[0].at);
            void'(sb.pop_front());
        end
    end

    // Drive a request now (caller is at a falling edge); e = sampling edge.
    task automatic req_now(input logic m, input logic d, input logic [31:0] a,
                           input logic [31:0] b, output int e);
        bus.ctrl_MULT     = m;
        bus.ctrl_DIV      = d;
        bus.data_operandA = a;
        bus.data_operandB = b;
        e = cyc + 1;
        @(negedge clock);
        bus.ctrl_MULT = 1'b0;
        bus.ctrl_DIV  = 1'b0;
    endtask

    task automatic push(input logic [31:0] r, input logic x, input int at, input string nm);
        exp_t t;
        t.res = r; t.exc = x; t.at = at; t.name = nm;
        sb.push_back(t);
    endtask

    task automatic wait_drain(input int maxc);
        for (int i = 0; i < maxc; i++) begin
            if (sb.size() == 0) break;
            @(negedge clock);
            #1;
        end
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got %0d pending, expected 0", sb.size());
            sb.delete();
        end
    endtask

    function automatic logic [31:0] flags();
        return {27'd0, bus.busy, bus.data_resultRDY, bus.data_exception,
                bus.dp_start_mult, bus.dp_start_div};
    endfunction

    int e, e2, s_m, s_d, s_b, s_r;

    initial begin
        bus.ctrl_MULT = 1'b0;
        bus.ctrl_DIV = 1'b0;
        bus.data_operandA = '0;
        bus.data_operandB = '0;
        reset = 1'b1;
        repeat (3) @(negedge clock);
        check32("reset_flags", flags(), 32'h0);
        check32("reset_result", bus.data_result, 32'h0);
        check32("reset_ops", bus.dp_operandA | bus.dp_operandB, 32'h0);
        reset = 1'b0;

        // Plain multiply 7*6
        @(negedge clock);
        s_m = n_smult; s_d = n_sdiv; s_b = n_busy;
        req_now(1'b1, 1'b0, 32'd7, 32'd6, e);
        push(32'd42, 1'b0, e + MC, "mul7x6");
        #1 check32("mul7x6_opA", bus.dp_operandA, 32'd7);
        wait_drain(MC + 10);
        check32("mul7x6_starts", 32'(n_smult - s_m), 32'd1);
        check32("mul7x6_busy", 32'(n_busy - s_b), 32'd32);
        check32("mul7x6_nodiv", 32'(n_sdiv - s_d), 32'd0);
        @(negedge clock); #1;
        check32("idle_flags", flags(), 32'h0);

        // Divide by zero
        s_d = n_sdiv; s_b = n_busy;
        req_now(1'b0, 1'b1, 32'd100, 32'd0, e);
        push(32'd0, 1'b1, e + 1, "div100by0");
        wait_drain(10);
        check32("div0_nostart", 32'(n_sdiv - s_d), 32'd0);
        check32("div0_busy", 32'(n_busy - s_b), 32'd1);

        // Divide 100/7
        @(negedge clock);
        s_d = n_sdiv; s_b = n_busy;
        req_now(1'b0, 1'b1, 32'd100, 32'd7, e);
        push(32'd14, 1'b0, e + DC, "div100by7");
        wait_drain(DC + 10);
        check32("div7_starts", 32'(n_sdiv - s_d), 32'd1);
        check32("div7_busy", 32'(n_busy - s_b), 32'd34);

        // Divide aborted by a multiply at busy cycle 10
        @(negedge clock);
        s_m = n_smult; s_d = n_sdiv;
        req_now(1'b0, 1'b1, 32'd100, 32'd7, e);
        repeat (9) @(negedge clock);
        req_now(1'b1, 1'b0, 32'd3, 32'd5, e2);
        push(32'd15, 1'b0, e2 + MC, "abort_mul3x5");
        wait_drain(MC + 10);
        check32("abort_div_starts", 32'(n_sdiv - s_d), 32'd1);
        check32("abort_mul_starts", 32'(n_smult - s_m), 32'd1);

        // Simultaneous multiply and divide: multiply wins
        @(negedge clock);
        s_m = n_smult; s_d = n_sdiv;
        req_now(1'b1, 1'b1, 32'd9, 32'd4, e);
        push(32'd36, 1'b0, e + MC, "both_mul9x4");
        wait_drain(MC + 10);
        check32("both_mul_starts", 32'(n_smult - s_m), 32'd1);
        check32("both_div_starts", 32'(n_sdiv - s_d), 32'd0);

        // Multiply overflow, then exception held until the next completion
        @(negedge clock);
        ovf_arm = 1'b1;
        req_now(1'b1, 1'b0, 32'h8000_0001, 32'd2, e);
        push(32'd2, 1'b1, e + MC, "ovf_mul");
        wait_drain(MC + 10);
        ovf_arm = 1'b0;
        repeat (5) @(negedge clock);
        #1;
        check32("ovf_exc_held", 32'(bus.data_exception), 32'd1);
        check32("ovf_result_held", bus.data_result, 32'd2);

        // Request landing in DONE: RDY still issued, next op starts same edge
        @(negedge clock);
        req_now(1'b1, 1'b0, 32'h0000_FFFF, 32'h0000_FFFF, e);
        push(32'hFFFE_0001, 1'b0, e + MC, "mulffff");
        #1 check32("exc_held_while_busy", 32'(bus.data_exception), 32'd1);
        for (int i = 0; i < MC + 5 && cyc < e + MC; i++) @(negedge clock);
        req_now(1'b1, 1'b0, 32'd4, 32'd5, e2);
        push(32'd20, 1'b0, e2 + MC, "done_mul4x5");
        #1 check32("done_restart_busy", 32'(bus.busy), 32'd1);
        wait_drain(MC + 10);

        // Reset at busy cycle 5 of a divide
        @(negedge clock);
        req_now(1'b0, 1'b1, 32'd50, 32'd5, e);
        repeat (4) @(negedge clock);
        reset = 1'b1;
        @(negedge clock); #1;
        check32("midreset_flags", flags(), 32'h0);
        check32("midreset_result", bus.data_result, 32'h0);
        check32("midreset_ops", bus.dp_operandA | bus.dp_operandB, 32'h0);
        reset = 1'b0;
        s_r = n_rdy;
        repeat (40) @(negedge clock);
        check32("midreset_no_rdy", 32'(n_rdy - s_r), 32'd0);

        // Recovery after reset
        req_now(1'b1, 1'b0, 32'd11, 32'd11, e);
        push(32'd121, 1'b0, e + MC, "mul11x11");
        wait_drain(MC + 10);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/multdiv_ctrl.md
MULTDIV_CTRL -- requirements
Module: multdiv_ctrl

Interface
REQ-001 Parameter MULT_CYCLES, default 32: datapath iterations per multiply, legal range 2..63.
REQ-002 Parameter DIV_CYCLES, default 34: datapath iterations per divide, legal range 2..63.
REQ-003 clock  input  1  sole clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 ctrl_MULT  input  1  one-cycle pulse requesting a multiply of the operands sampled in the same cycle.
REQ-006 ctrl_DIV  input  1  one-cycle pulse requesting a divide (A / B) of the operands sampled in the same cycle.
REQ-007 data_operandA, data_operandB  input  32 each  request operands.
REQ-008 dp_result  input  32  iterative datapath result, valid in the last busy cycle.
REQ-009 dp_overflow  input  1  datapath multiply overflow flag, valid in the last busy cycle.
REQ-010 dp_start_mult, dp_start_div  output  1 each  one-cycle start pulses to the shared datapath.
REQ-011 dp_operandA, dp_operandB  output  32 each  registered operands, held stable for the whole operation.
REQ-012 data_result  output  32  captured result, held until the next completion.
REQ-013 data_resultRDY  output  1  one-cycle completion pulse.
REQ-014 data_exception  output  1  valid with data_resultRDY; held with data_result.
REQ-015 busy  output  1  high while an operation is in progress (pipeline stall).

Function
REQ-016 The state machine SHALL have the states IDLE, MULT, DIV and DONE, with a 6-bit iteration counter.
REQ-017 A request sampled at edge k SHALL latch the operands, enter MULT or DIV, clear the counter, and drive the matching dp_start_* high for exactly the cycle after edge k.
REQ-018 If ctrl_MULT and ctrl_DIV are both high at an edge, the multiply SHALL win and the divide request SHALL be discarded.
REQ-019 In MULT or DIV the counter SHALL increment by one per cycle, and busy SHALL be 1.
REQ-020 At the edge where the counter equals N-1 (N = MULT_CYCLES or DIV_CYCLES), the block SHALL capture dp_result into data_result, capture the exception flag, and enter DONE.
REQ-021 The exception flag SHALL be dp_overflow for a multiply and 0 for a divide with a nonzero divisor.
REQ-022 In DONE, data_resultRDY SHALL be 1 for exactly one cycle and busy SHALL be 0, and the next edge SHALL return the block to IDLE unless a new request is present.
REQ-023 Request-to-RDY latency SHALL be N+1 cycles: request sampled at edge 0, RDY high in the cycle after edge N.
REQ-024 A divide with data_operandB == 0 SHALL skip the datapath: no dp_start_div, enter DONE at the next edge, data_result = 0, data_exception = 1.
REQ-025 A new request arriving in MULT or DIV SHALL abort the current operation without an RDY pulse and restart per REQ-017 with the new operands.
REQ-026 A new request arriving in DONE SHALL still produce that cycle's RDY and SHALL start the new operation at the same edge.
REQ-027 data_result and data_exception SHALL change only at the completion edges of REQ-020 and REQ-024, and at reset.

Reset
REQ-028 When reset is high at an edge, the block SHALL enter IDLE, clear the counter, and clear every output register: all outputs 0 (busy 0, RDY 0, data_result 0, data_exception 0, dp_* 0).
REQ-029 Reset SHALL take priority over any simultaneous request, and reset mid-operation SHALL abandon the operation without an RDY pulse.

Structure
REQ-030 Shared package multdiv_pkg SHALL hold the state enumeration, the 32-bit data width constant, the 6-bit counter width constant, and the MULT_CYCLES and DIV_CYCLES default constants.
REQ-031 The iteration counter SHALL be a sub-module, multdiv_cycle_counter, with a synchronous clear and a terminal-count compare against a parameter.
REQ-032 All outputs SHALL be registered, with no combinational path from any input to any output.

Verification
REQ-033 Scenario: ctrl_MULT with A = 7, B = 6, model returns 42 -> dp_start_mult pulses once, busy 32 cycles, RDY 33 cycles after the request, result 42, exception 0.
REQ-034 Scenario: ctrl_DIV with A = 100, B = 0 -> no dp_start_div, RDY in the cycle after edge 1, result 0, exception 1.
REQ-035 Scenario: ctrl_DIV with A = 100, B = 7, then ctrl_MULT at busy cycle 10 -> no RDY for the divide, the multiply completes 33 cycles after its own request.
REQ-036 Scenario: ctrl_MULT and ctrl_DIV in the same cycle -> only dp_start_mult pulses, latency 33.
REQ-037 Scenario: reset asserted at busy cycle 5 of a divide -> all outputs 0 next cycle, no RDY ever issued.
REQ-038 Scenario: multiply with dp_overflow = 1 in the last busy cycle -> RDY with exception 1, exception held until the next completion.
